// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the 16-bit/8-bit divider family.
// The divider and its shift-add reconstructor both import this package.
package div_pkg;

    localparam int DIV_QW = 16;
    localparam int DIV_BW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_16bit_check.sv
// Shift-add reconstructor: dividend = q*b + r, with a flag for whether the result
// fits back into the divider's QW-bit dividend range.
module div_16bit_check
    import div_pkg::*;
#(
    parameter int QW = DIV_QW,
    parameter int BW = DIV_BW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QW-1:0]    q,
    input  logic [BW-1:0]    b,
    input  logic [QW-1:0]    r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW+BW-1:0] dividend,
    output logic             fits
);

    localparam int CW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);

    div_state_t       r_state;
    logic [QW+BW-1:0] r_acc;
    logic [QW+BW-1:0] r_mcand;
    logic [BW-1:0]    r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [QW+BW-1:0] r_dividend;
    logic             r_fits;
    logic [QW+BW-1:0] w_accNext;

    // No early exit on zero multiplier bits, so latency is always exactly BW edges.
    assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign dividend  = r_dividend;
    assign fits      = r_fits;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_fits     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc    <= {{BW{1'b0}}, r};
                        r_mcand  <= {{BW{1'b0}}, q};
                        r_mplier <= b;
                        r_cnt    <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_dividend <= w_accNext;
                        r_fits     <= (w_accNext[QW+BW-1:QW] == '0);
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    // Result registers are left alone on retire; only the state moves.
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_16bit_check.sv
// Directed self-checking bench for div_16bit_check: values, latency,
// backpressure and reset behaviour against hand-computed results.
module tb_div_16bit_check;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] q;
    logic [7:0]  b;
    logic [15:0] r;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] dividend;
    logic        fits;

    int checks;
    int errors;

    div_16bit_check dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .b         (b),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend),
        .fits      (fits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents operands at a falling edge and lets the next rising edge accept them,
    // then scrambles the operand inputs to show they are not sampled again.
    task automatic startTxn(input logic [15:0] qi, input logic [7:0] bi, input logic [15:0] ri);
        @(negedge clk);
        q        = qi;
        b        = bi;
        r        = ri;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        q        = 16'h5A5A;
        b        = 8'hC3;
        r        = 16'h3C3C;
    endtask

    // Counts rising edges after the accept edge until out_valid is seen; -1 on timeout.
    task automatic waitDone(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q = '0; b = '0; r = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++;
        if (dividend !== 24'h0) begin errors++; $display("[TB] FAIL reset_dividend got %06h want 000000", dividend); end
        checks++;
        if (fits !== 1'b0) begin errors++; $display("[TB] FAIL reset_fits got %0b want 0", fits); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready_during_rst got %0b want 0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_after got %0b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        startTxn(16'h0100, 8'h10, 16'h0005);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_in_ready_busy got %0b want 0", in_ready); end
        waitDone(lat);
        checks++;
        if (lat !== 8) begin errors++; $display("[TB] FAIL basic_latency got %0d want 8", lat); end
        checks++;
        if (dividend !== 24'h001005) begin errors++; $display("[TB] FAIL basic_dividend got %06h want 001005", dividend); end
        checks++;
        if (fits !== 1'b1) begin errors++; $display("[TB] FAIL basic_fits got %0b want 1", fits); end
        retire();
    endtask

    task automatic test_zero_divisor();
        int lat;
        startTxn(16'h1234, 8'h00, 16'hABCD);
        waitDone(lat);
        checks++;
        if (lat !== 8) begin errors++; $display("[TB] FAIL zero_latency got %0d want 8", lat); end
        checks++;
        if (dividend !== 24'h00ABCD) begin errors++; $display("[TB] FAIL zero_dividend got %06h want 00abcd", dividend); end
        checks++;
        if (fits !== 1'b1) begin errors++; $display("[TB] FAIL zero_fits got %0b want 1", fits); end
        retire();
    endtask

    task automatic test_max();
        int lat;
        startTxn(16'hFFFF, 8'hFF, 16'hFFFF);
        waitDone(lat);
        checks++;
        if (lat !== 8) begin errors++; $display("[TB] FAIL max_latency got %0d want 8", lat); end
        checks++;
        if (dividend !== 24'hFFFF00) begin errors++; $display("[TB] FAIL max_dividend got %06h want ffff00", dividend); end
        checks++;
        if (fits !== 1'b0) begin errors++; $display("[TB] FAIL max_fits got %0b want 0", fits); end
        retire();
    endtask

    // out_ready is raised before the result exists; it must not shortcut anything.
    task automatic test_round_trip();
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        startTxn(16'h1B46, 8'h07, 16'h0005);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rt_early_ready got %0b want 0", out_valid); end
        waitDone(lat);
        checks++;
        if (lat !== 8) begin errors++; $display("[TB] FAIL rt_latency got %0d want 8", lat); end
        checks++;
        if (dividend !== 24'h00BEEF) begin errors++; $display("[TB] FAIL rt_dividend got %06h want 00beef", dividend); end
        checks++;
        if (fits !== 1'b1) begin errors++; $display("[TB] FAIL rt_fits got %0b want 1", fits); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rt_retire got valid=%0b ready=%0b want valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        startTxn(16'h0003, 8'h05, 16'h0002);
        waitDone(lat);
        checks++;
        if (lat !== 8) begin errors++; $display("[TB] FAIL bp_latency got %0d want 8", lat); end
        for (int i = 0; i < 5; i++) begin
            q        = 16'h0FFF;
            b        = 8'h11;
            r        = 16'h0123;
            in_valid = (i == 2);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dividend !== 24'h000011 || fits !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_stall cycle %0d got valid=%0b ready=%0b div=%06h fits=%0b want 1 0 000011 1",
                         i, out_valid, in_ready, dividend, fits);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_retire got valid=%0b ready=%0b want valid=0 ready=1", out_valid, in_ready);
        end
        checks++;
        if (dividend !== 24'h000011) begin errors++; $display("[TB] FAIL bp_hold_after_retire got %06h want 000011", dividend); end
        repeat (10) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_ignored_ops got valid=%0b ready=%0b want valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        startTxn(16'h4321, 8'hA5, 16'h0077);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dividend !== 24'h0 || fits !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_state got valid=%0b div=%06h fits=%0b ready=%0b want 0 000000 0 0",
                     out_valid, dividend, fits, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_idle got %0b want 1", in_ready); end
        startTxn(16'h0002, 8'h03, 16'h0001);
        waitDone(lat);
        checks++;
        if (lat !== 8) begin errors++; $display("[TB] FAIL midrst_latency got %0d want 8", lat); end
        checks++;
        if (dividend !== 24'h000007 || fits !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_next got div=%06h fits=%0b want 000007 1", dividend, fits);
        end
        retire();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_zero_divisor();
        test_max();
        test_round_trip();
        test_backpressure();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
